// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache word requests onto a single-port RAM (dcache priority).
// Optional icache starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
            $error("mem_arbiter: STARVE_LIMIT must be within 1..15");
        end
    endgenerate

    state_t r_state;
    logic   r_err;
    logic   w_dreq;
    logic   w_access;
    logic   w_error;
    logic   w_force_i;

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == RAM_ACCESS);
    assign w_error  = (ramstate == RAM_ERROR);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] r_starve_cnt;

    assign w_force_i = iREN && (r_starve_cnt >= LIMIT);

    // Counts dcache wins that left a pending icache request waiting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve_cnt <= 4'd0;
        end else if (r_state == IDLE) begin
            if (!iREN || w_force_i || !w_dreq)
                r_starve_cnt <= 4'd0;
            else
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`else
    assign w_force_i = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            if (r_state != IDLE && w_error)
                r_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_force_i)
                        r_state <= IGRANT;
                    else if (w_dreq)
                        r_state <= DGRANT;
                    else if (iREN)
                        r_state <= IGRANT;
                end
                DGRANT: begin
                    if (!w_dreq || w_access || w_error)
                        r_state <= IDLE;
                end
                IGRANT: begin
                    if (!iREN || w_access || w_error)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Enables follow the live request so an abort drops them in the same cycle.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'd0;
        dload    = 32'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        case (r_state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dload    = ramload;
                dwait    = ~(w_dreq & w_access);
            end
            IGRANT: begin
                ramaddr  = iaddr;
                ramREN   = iREN;
                iload    = ramload;
                iwait    = ~(iREN & w_access);
            end
            default: ;
        endcase
    end

    assign busy = (r_state != IDLE);
    assign err  = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner-case sequences and
// a completion scoreboard driven from a small latency-programmable RAM model.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        busy, err;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    // RAM model: ACCESS after ram_lat BUSY cycles of continuous enable.
    int          ram_cnt;
    int          ram_lat;
    logic        force_err;
    logic [31:0] ram_data;

    always @(posedge CLK) begin
        if (!(ramREN | ramWEN)) ram_cnt <= 0;
        else                    ram_cnt <= ram_cnt + 1;
    end

    always_comb begin
        ramstate = 2'd0;
        if (ramREN | ramWEN) begin
            if (force_err)             ramstate = 2'd3;
            else if (ram_cnt >= ram_lat) ramstate = 2'd2;
            else                       ramstate = 2'd1;
        end
    end
    assign ramload = ram_data;

    typedef struct {
        bit          is_d;
        logic [31:0] load;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit          is_d;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] rdata;
        int          lat;
        bit          ferr;
        bit          exp_ren;
        bit          exp_wen;
        logic [31:0] exp_store;
    } vec_t;

    int errors = 0;
    int checks = 0;
    bit sb_en = 1'b1;
    int icomp, dcomp, first_i_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input bit is_d, input logic [31:0] data);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %s completion load=%h want none", is_d ? "dcache" : "icache", data);
        end else begin
            e = sb_q.pop_front();
            if (e.is_d != is_d || e.load !== data) begin
                errors++;
                $display("FAIL sb_completion: got %s load=%h want %s load=%h",
                         is_d ? "dcache" : "icache", data, e.is_d ? "dcache" : "icache", e.load);
            end else begin
                $display("txn %s load=%h ok", is_d ? "dcache" : "icache", data);
            end
        end
    endtask

    // Every sampling point goes through here so completions are never missed.
    task automatic tick();
        @(negedge CLK);
        if (!iwait) begin
            if (first_i_d < 0) first_i_d = dcomp;
            icomp++;
            if (sb_en) pop_chk(1'b0, iload);
        end
        if (!dwait) begin
            dcomp++;
            if (sb_en) pop_chk(1'b1, dload);
        end
    endtask

    task automatic drop_all();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; force_err = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vec_t v;
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h2108_0001, 0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 32'h0000_0000, 1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h5555_AAAA, 32'h1234_5678, 2, 1'b0, 1'b1, 1'b0, 32'h5555_AAAA};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_0001, 32'h0000_0077, 0, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h8765_4321, 3, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'hFFFF_0000, 0, 1'b1, 1'b1, 1'b0, 32'h0};

        icomp = 0; dcomp = 0; first_i_d = -1;
        ram_lat = 0; ram_data = 32'h0; force_err = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b1;

        // Reset with requests asserted: everything at reset values.
        tick();
        chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1);
        chk("rst_iload", iload, 0); chk("rst_dload", dload, 0);
        chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);
        chk("rst_busy", busy, 0); chk("rst_err", err, 0);
        @(posedge CLK); #1 drop_all();
        @(posedge CLK); #1 nRST = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            @(posedge CLK); #1;
            ram_lat = v.lat; ram_data = v.rdata; force_err = v.ferr;
            if (v.is_d) begin
                dREN = v.ren; dWEN = v.wen; daddr = v.addr; dstore = v.store;
            end else begin
                iREN = 1'b1; iaddr = v.addr;
            end
            if (!v.ferr) sb_q.push_back('{v.is_d, v.rdata});
            tick();
            chk($sformatf("v%0d_idle_busy", k), busy, 0);
            chk($sformatf("v%0d_idle_ren", k), ramREN, 0);
            for (int g = 0; g <= v.lat; g++) begin
                tick();
                chk($sformatf("v%0d_g%0d_busy", k, g), busy, 1);
                chk($sformatf("v%0d_g%0d_ramREN", k, g), ramREN, v.exp_ren);
                chk($sformatf("v%0d_g%0d_ramWEN", k, g), ramWEN, v.exp_wen);
                chk($sformatf("v%0d_g%0d_ramaddr", k, g), ramaddr, v.addr);
                chk($sformatf("v%0d_g%0d_ramstore", k, g), ramstore, v.exp_store);
            end
            @(posedge CLK); #1 drop_all();
            tick();
            chk($sformatf("v%0d_after_busy", k), busy, 0);
            chk($sformatf("v%0d_sb_drain", k), sb_q.size(), 0);
            chk($sformatf("v%0d_err", k), err, v.ferr);
        end

        // Contention: dcache first, one IDLE bubble, then icache.
        @(posedge CLK); #1;
        ram_lat = 0; ram_data = 32'h0BAD_F00D;
        iREN = 1'b1; iaddr = 32'h0000_0400;
        dWEN = 1'b1; daddr = 32'h0000_0080; dstore = 32'hDEAD_BEEF;
        sb_q.push_back('{1'b1, 32'h0BAD_F00D});
        sb_q.push_back('{1'b0, 32'h0BAD_F00D});
        tick();
        chk("ct_idle_busy", busy, 0);
        tick();
        chk("ct_d_ramWEN", ramWEN, 1); chk("ct_d_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("ct_d_ramaddr", ramaddr, 32'h80); chk("ct_d_iwait", iwait, 1);
        @(posedge CLK); #1 dWEN = 1'b0;
        tick();
        chk("ct_bubble_busy", busy, 0); chk("ct_bubble_iwait", iwait, 1);
        tick();
        chk("ct_i_ramREN", ramREN, 1); chk("ct_i_ramaddr", ramaddr, 32'h400);
        @(posedge CLK); #1 drop_all();
        tick();
        chk("ct_sb_drain", sb_q.size(), 0);

        // Abort: dcache read dropped after one BUSY cycle.
        @(posedge CLK); #1;
        ram_lat = 10; dREN = 1'b1; daddr = 32'h0000_0500;
        tick();
        tick();
        chk("ab_busy_ren", ramREN, 1);
        @(posedge CLK); #1 dREN = 1'b0;
        tick();
        chk("ab_drop_ren", ramREN, 0); chk("ab_drop_dwait", dwait, 1);
        tick();
        chk("ab_idle_busy", busy, 0); chk("ab_err_sticky", err, 1);

        // Starvation: both requests held continuously.
        sb_en = 1'b0; icomp = 0; dcomp = 0; first_i_d = -1; ram_lat = 0;
        @(posedge CLK); #1;
        iREN = 1'b1; iaddr = 32'h0000_0600; dREN = 1'b1; daddr = 32'h0000_0700;
        for (int c = 0; c < 40; c++) tick();
        @(posedge CLK); #1 drop_all();
        tick();
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_d_before_i", first_i_d, 4);
        chk("starve_i_granted", (icomp > 0), 1);
`else
        chk("starve_icomp", icomp, 0);
        chk("starve_dcomp", dcomp, 20);
`endif
        sb_en = 1'b1;

        // Reset asserted mid-grant drops enables immediately.
        @(posedge CLK); #1;
        ram_lat = 100; dREN = 1'b1; daddr = 32'h0000_0044;
        tick();
        tick();
        chk("mr_grant_ren", ramREN, 1);
        #1 nRST = 1'b0;
        #1;
        chk("mr_ren", ramREN, 0); chk("mr_busy", busy, 0);
        chk("mr_dwait", dwait, 1); chk("mr_err", err, 0);
        dREN = 1'b0;
        @(posedge CLK); #1 nRST = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Sits between the icache/dcache pair and the single-port RAM.
- Serialises word-wide requests from both caches onto the one RAM port, with dcache priority and an optional icache starvation guard.
- Returns per-requester wait/load handshakes matching the existing `caches_if` convention: `*wait` low means data/ack valid this cycle.
- Also reports sticky RAM-error status.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive dcache grants with icache pending before icache is forced (guard only); legal range 1–15.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  low = iload valid this cycle
- iload  out  32  icache read data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  low = dload valid / write accepted this cycle
- dload  out  32  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- busy  out  1  FSM not in IDLE
- err  out  1  sticky: set on any ramstate==ERROR during a grant

## Operation
- FSM states: IDLE, DGRANT, IGRANT; state register only, outputs decoded from state plus inputs.
- IDLE:
  - dREN|dWEN → DGRANT.
  - Else iREN → IGRANT.
  - Else stay IDLE.
  - All ram enables low.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, ramREN=dREN&~dWEN; write wins if both are asserted.
  - dload=ramload.
- IGRANT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0, iload=ramload.
- Completion: ramstate==ACCESS in a grant state.
  - Owning requester's wait is driven low combinationally that same cycle.
  - FSM → IDLE next edge.
- Abort: owning request deasserts before ACCESS.
  - Ram enables drop immediately (combinational on the request).
  - FSM → IDLE next edge; no wait pulse.
- Error: ramstate==ERROR in a grant state.
  - err set (sticky until reset); wait stays high.
  - FSM → IDLE; requester retries via normal arbitration.
- Non-owning requester: wait=1, load=0 at all times.
- Idle datapath: ramaddr, ramstore, iload and dload are driven 0 when not granted/owning.
- Requests must be held stable (address/data) from assertion until wait goes low or the request is dropped.

## Timing
- Reset (async, nRST low): state=IDLE, iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, busy=0, err=0, starve counter=0.
- Reset mid-grant: enables drop on the reset assertion, with no completion pulse.
- Request registered: arbitration decision at the edge after the request is seen in IDLE.
  - Minimum latency, request to wait-low: 2 cycles (IDLE→grant edge, then ACCESS in the first grant cycle).
- One mandatory IDLE bubble between consecutive transactions; back-to-back dcache words therefore take ≥2 cycles each.
- ramstate BUSY/FREE in a grant state: hold grant, no timeout.
- Simultaneous iREN and dREN/dWEN in IDLE: dcache wins unless the starvation guard forces icache.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - 4-bit counter increments on each DGRANT entry while iREN=1.
  - Clears on IGRANT entry or when iREN=0 in IDLE.
  - When the counter reaches STARVE_LIMIT and iREN=1 in IDLE, icache is granted even if a dcache request is pending.
- Macro undefined: strict dcache priority; the counter is absent, and icache can starve indefinitely.

## Test plan
- Reset: hold nRST=0 with iREN=1, dWEN=1 → all outputs at reset values, busy=0.
- Lone icache read: iREN=1, iaddr=0x0000_0040, RAM returns ACCESS in the first grant cycle with ramload=0x2108_0001 → iwait=0 exactly on cycle 2 with iload=0x2108_0001; ramREN=1, ramaddr=0x40 during grant; then IDLE.
- Contention: iREN=1 and dWEN=1 (daddr=0x80, dstore=0xDEAD_BEEF) together → DGRANT first, ramWEN=1, ramstore=0xDEADBEEF, dwait low on ACCESS; IGRANT follows after one IDLE bubble; iwait stays high until then.
- Abort and error:
  - dREN dropped after 1 BUSY cycle → ramREN falls that cycle, no dwait pulse, IDLE next.
  - ramstate=ERROR during IGRANT → err=1 and stays 1, iwait stays high.
- Starvation (guard on, STARVE_LIMIT=4): iREN held, dREN re-asserted continuously → exactly 4 DGRANTs, then IGRANT; with guard off, zero IGRANTs over 20 transactions.
- Dual dcache enable: dREN=1 and dWEN=1 → ramWEN=1, ramREN=0.
